// File: rtl/seq_alu_if.sv
//==============================================================================
// Module      : seq_alu_if
// Description : Operand/result valid-ready bundle between issue, ALU and writeback.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface seq_alu_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (
    output in_valid, alu_control, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_control, operand_a, operand_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

`default_nettype wire

// File: rtl/seq_alu.sv
//==============================================================================
// Module      : seq_alu
// Description : Execute-stage ALU, 1-cycle logic/arith ops and, when
//               SEQ_ALU_SHIFT_EN is defined, 1-bit/cycle iterative shifts.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_alu #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_alu_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DONE  = 2'd2
`ifdef SEQ_ALU_SHIFT_EN
    , SHIFT = 2'd1
`endif
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic            r_illegal;
  logic            r_out_valid;

  logic            w_in_ready;
  logic            w_accept;
  logic [XLEN-1:0] w_res;
  logic            w_ill;

`ifdef SEQ_ALU_SHIFT_EN
  logic [XLEN-1:0] r_work;
  logic [SHW-1:0]  r_cnt;
  logic [1:0]      r_op;
  logic [XLEN-1:0] w_step;
  logic            w_is_shift;
  logic [SHW-1:0]  w_shamt;

  assign w_shamt = bus.operand_b[SHW-1:0];

  // r_op holds alu_control[1:0]: 00 SLL, 01 SRL, 10 SRA
  always_comb begin
    case (r_op)
      2'b00:   w_step = r_work << 1;
      2'b01:   w_step = r_work >> 1;
      default: w_step = {r_work[XLEN-1], r_work[XLEN-1:1]};
    endcase
  end
`endif

  assign w_in_ready = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  always_comb begin
    w_res = '0;
    w_ill = 1'b0;
`ifdef SEQ_ALU_SHIFT_EN
    w_is_shift = 1'b0;
`endif
    case (bus.alu_control)
      4'b0000: w_res = bus.operand_a & bus.operand_b;
      4'b0001: w_res = bus.operand_a | bus.operand_b;
      4'b0010: w_res = bus.operand_a + bus.operand_b;
      4'b0110: w_res = bus.operand_a - bus.operand_b;
      4'b0111: w_res = {{(XLEN-1){1'b0}},
                        ($signed(bus.operand_a) < $signed(bus.operand_b))};
`ifdef SEQ_ALU_SHIFT_EN
      // A zero-distance shift completes immediately with operand_a
      4'b1000, 4'b1001, 4'b1010: begin
        w_res      = bus.operand_a;
        w_is_shift = 1'b1;
      end
`endif
      default: w_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef SEQ_ALU_SHIFT_EN
      r_work      <= '0;
      r_cnt       <= '0;
      r_op        <= 2'b00;
`endif
    end else begin
      case (r_state)
`ifdef SEQ_ALU_SHIFT_EN
        SHIFT: begin
          r_work <= w_step;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == SHW'(1)) begin
            r_result    <= w_step;
            r_zero      <= (w_step == '0);
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
`endif
        default: begin
          if (w_accept) begin
`ifdef SEQ_ALU_SHIFT_EN
            if (w_is_shift && (w_shamt != '0)) begin
              r_work      <= bus.operand_a;
              r_cnt       <= w_shamt;
              r_op        <= bus.alu_control[1:0];
              r_out_valid <= 1'b0;
              r_state     <= SHIFT;
            end else
`endif
            begin
              r_result    <= w_res;
              r_zero      <= (w_res == '0);
              r_illegal   <= w_ill;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end
          end else if ((r_state == DONE) && bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.illegal   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu: directed vector table, hand-written handshake/reset
// sequences and randomized ops against a behavioural model.
`default_nettype none

module tb_seq_alu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  seq_alu_if #(.XLEN(32)) bus ();

  seq_alu #(.XLEN(32), .SHW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
    logic        il;
    int          lat;
  } vec_t;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Reference: results from plain arithmetic on the opcode meaning
  function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic il, output int lat);
    int sh;
    sh  = int'(b[4:0]);
    r   = 32'd0;
    il  = 1'b0;
    lat = 1;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef SEQ_ALU_SHIFT_EN
      4'b1000: begin r = a << sh; lat = 1 + sh; end
      4'b1001: begin r = a >> sh; lat = 1 + sh; end
      4'b1010: begin r = $signed(a) >>> sh; lat = 1 + sh; end
`endif
      default: il = 1'b1;
    endcase
  endfunction

  // One complete transaction; inputs change and outputs are sampled on negedges
  task automatic run_op(input string nm, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic ez,
                        input logic eil, input int elat, input int stall);
    int w;
    int lat;
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.alu_control = c;
    bus.operand_a   = a;
    bus.operand_b   = b;
    bus.out_ready   = 1'b0;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) chk1({nm, "_accept_timeout"}, 1'b0, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 64) begin
      chk1({nm, "_busy_in_ready"}, bus.in_ready, 1'b0);
      @(negedge clk);
      lat++;
    end
    chk32({nm, "_latency"}, 32'(lat), 32'(elat));
    for (int i = 0; i <= stall; i++) begin
      chk1 ({nm, "_valid"},    bus.out_valid, 1'b1);
      chk1 ({nm, "_in_ready"}, bus.in_ready,  1'b0);
      chk32({nm, "_result"},   bus.result,    er);
      chk1 ({nm, "_zero"},     bus.zero,      ez);
      chk1 ({nm, "_illegal"},  bus.illegal,   eil);
      if (i < stall) @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk1({nm, "_drained"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[$];
    logic [3:0]  rc;
    logic [31:0] ra, rb, mr;
    logic        mil;
    int          mlat;
    logic [3:0]  codes[9];

    bus.in_valid    = 1'b0;
    bus.alu_control = 4'd0;
    bus.operand_a   = 32'd0;
    bus.operand_b   = 32'd0;
    bus.out_ready   = 1'b0;

    tbl.push_back('{4'b0010, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1});
    tbl.push_back('{4'b0110, 32'd9,          32'd3,          32'd6,          1'b0, 1'b0, 1});
    tbl.push_back('{4'b0111, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0, 1});
    tbl.push_back('{4'b0111, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0, 1});
    tbl.push_back('{4'b0000, 32'hF0,         32'h0F,         32'd0,          1'b1, 1'b0, 1});
    tbl.push_back('{4'b0001, 32'hF0,         32'h0F,         32'hFF,         1'b0, 1'b0, 1});
    tbl.push_back('{4'b0110, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 1'b0, 1});
    tbl.push_back('{4'b0010, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0, 1});
    tbl.push_back('{4'b0101, 32'd3,          32'd4,          32'd0,          1'b1, 1'b1, 1});
    tbl.push_back('{4'b1111, 32'hAA,         32'h55,         32'd0,          1'b1, 1'b1, 1});
`ifdef SEQ_ALU_SHIFT_EN
    tbl.push_back('{4'b1010, 32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0, 1'b0, 5});
    tbl.push_back('{4'b1001, 32'h8000_0000,  32'h24,         32'h0800_0000,  1'b0, 1'b0, 5});
    tbl.push_back('{4'b1000, 32'd1,          32'd31,         32'h8000_0000,  1'b0, 1'b0, 32});
    tbl.push_back('{4'b1000, 32'h1234,       32'd0,          32'h1234,       1'b0, 1'b0, 1});
    tbl.push_back('{4'b1001, 32'h1,          32'd1,          32'd0,          1'b1, 1'b0, 2});
`else
    tbl.push_back('{4'b1000, 32'd5,          32'd4,          32'd0,          1'b1, 1'b1, 1});
    tbl.push_back('{4'b1001, 32'd5,          32'd1,          32'd0,          1'b1, 1'b1, 1});
    tbl.push_back('{4'b1010, 32'h8000_0000,  32'd4,          32'd0,          1'b1, 1'b1, 1});
`endif

    // Reset state
    #1;
    chk1 ("rst_out_valid", bus.out_valid, 1'b0);
    chk32("rst_result",    bus.result,    32'd0);
    chk1 ("rst_zero",      bus.zero,      1'b0);
    chk1 ("rst_illegal",   bus.illegal,   1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk1("rst_in_ready", bus.in_ready, 1'b1);

    foreach (tbl[i])
      run_op($sformatf("vec%0d", i), tbl[i].c, tbl[i].a, tbl[i].b,
             tbl[i].r, tbl[i].z, tbl[i].il, tbl[i].lat, 0);

    // SUB 3-3 held four cycles with out_ready low
    run_op("sub_stall", 4'b0110, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0, 1, 4);

    // SLT then AND back-to-back with out_ready held high
    @(negedge clk);
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.alu_control = 4'b0111;
    bus.operand_a   = 32'hFFFF_FFFF;
    bus.operand_b   = 32'd1;
    @(negedge clk);
    chk1 ("b2b_slt_valid",  bus.out_valid, 1'b1);
    chk32("b2b_slt_result", bus.result,    32'd1);
    chk1 ("b2b_in_ready",   bus.in_ready,  1'b1);
    bus.alu_control = 4'b0000;
    bus.operand_a   = 32'hF0;
    bus.operand_b   = 32'h0F;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk1 ("b2b_and_valid",  bus.out_valid, 1'b1);
    chk32("b2b_and_result", bus.result,    32'd0);
    chk1 ("b2b_and_zero",   bus.zero,      1'b1);
    @(negedge clk);
    chk1("b2b_drained", bus.out_valid, 1'b0);
    bus.out_ready = 1'b0;

    // Randomized ops against the model, with random writeback stalls
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
              4'b1000, 4'b1001, 4'b1010, 4'b0011};
    for (int n = 0; n < 150; n++) begin
      rc = codes[$urandom_range(0, 8)];
      if ($urandom_range(0, 9) == 0) rc = 4'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 7) == 0) rb = ra;
      model(rc, ra, rb, mr, mil, mlat);
      run_op($sformatf("rnd%0d_op%0h", n, rc), rc, ra, rb, mr, (mr == 32'd0), mil, mlat,
             $urandom_range(0, 2));
    end

    // Reset asserted while an op is in flight clears everything at once
    run_op("pre_rst", 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1, 0);
    @(negedge clk);
    bus.in_valid = 1'b1;
`ifdef SEQ_ALU_SHIFT_EN
    bus.alu_control = 4'b1000;
    bus.operand_a   = 32'd1;
    bus.operand_b   = 32'd31;
`else
    bus.alu_control = 4'b0010;
    bus.operand_a   = 32'd5;
    bus.operand_b   = 32'd7;
`endif
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk1 ("midrst_out_valid", bus.out_valid, 1'b0);
    chk32("midrst_result",    bus.result,    32'd0);
    chk1 ("midrst_zero",      bus.zero,      1'b0);
    chk1 ("midrst_illegal",   bus.illegal,   1'b0);
    chk1 ("midrst_in_ready",  bus.in_ready,  1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst_add", 4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
